// File: rtl/out_port_uart_tx_if.sv
// -----------------------------------------------------------------------------
// out_port_uart_tx_if
// Groups the output-stage strobe/data and the UART status signals.
//   master : control-unit side; drives LO and DATA_IN, observes TX and flags.
//   slave  : UART side; receives LO and DATA_IN, drives TX, BUSY,
//            FIFO_FULL, FIFO_EMPTY and OVF.
// -----------------------------------------------------------------------------
interface out_port_uart_tx_if;
  logic       LO;
  logic [7:0] DATA_IN;
  logic       TX;
  logic       BUSY;
  logic       FIFO_FULL;
  logic       FIFO_EMPTY;
  logic       OVF;

  modport master (
    output LO, DATA_IN,
    input  TX, BUSY, FIFO_FULL, FIFO_EMPTY, OVF
  );

  modport slave (
    input  LO, DATA_IN,
    output TX, BUSY, FIFO_FULL, FIFO_EMPTY, OVF
  );
endinterface

// File: rtl/out_port_uart_tx.sv
// -----------------------------------------------------------------------------
// out_port_uart_tx
// Captures each byte loaded into the CPU output register (falling edge of the
// active-low LO strobe), buffers it in a small FIFO and sends it as an 8N1 UART
// frame on TX, LSB first.
// Ports:
//   clk  : system clock, rising edge.
//   rst  : synchronous active-low reset.
//   bus  : slave modport of out_port_uart_tx_if
//          LO, DATA_IN        - load strobe and byte from the output stage
//          TX                 - serial line, idles high, driven from a flop
//          BUSY               - frame in progress or FIFO non-empty
//          FIFO_FULL/EMPTY    - FIFO occupancy flags
//          OVF                - sticky, a byte was dropped on a full FIFO
// -----------------------------------------------------------------------------
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  out_port_uart_tx_if.slave   bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [BAUD_W-1:0] baud_q,    baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q,   shift_d;
  logic              tx_q,      tx_d;
  logic              ovf_q,     ovf_d;
  logic              lo_d_q,    lo_d_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];

  logic fifo_empty_s;
  logic fifo_full_s;
  logic push_s;
  logic pop_s;
  logic push_ok_s;

  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_q == CNT_FULL);

  // Falling edge of LO against its registered copy: one push per load strobe.
  assign push_s = (~bus.LO) & lo_d_q;

  // The FSM only takes a byte from IDLE, so a freshly pushed byte is never
  // popped on its own push edge.
  assign pop_s = (state_q == ST_IDLE) & ~fifo_empty_s;

  // A full FIFO still accepts a push when a slot is freed on the same edge.
  assign push_ok_s = push_s & (~fifo_full_s | pop_s);

  assign bus.TX         = tx_q;
  assign bus.OVF        = ovf_q;
  assign bus.FIFO_EMPTY = fifo_empty_s;
  assign bus.FIFO_FULL  = fifo_full_s;
  assign bus.BUSY       = (state_q != ST_IDLE) | ~fifo_empty_s;

  // FIFO next-state: write on accepted push, read pointer advances on pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lo_d_d   = bus.LO;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = bus.DATA_IN;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    ovf_d   = ovf_q | (push_s & fifo_full_s & ~pop_s);
  end

  // Transmit FSM next-state; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          shift_d   = mem_q[rd_ptr_q];
          baud_d    = {BAUD_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = {BAUD_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
          tx_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // Next bit is shift_q[1]; it lands in bit 0 after this shift.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
          tx_d   = shift_q[0];
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
          tx_d   = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        baud_d    = {BAUD_W{1'b0}};
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
  end

  // All state flops; reset aborts any frame in flight and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= {BAUD_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      lo_d_q    <= 1'b1;
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      mem_q     <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      lo_d_q    <= lo_d_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
Downstream consumer of the CPU output stage. It captures each byte the control unit loads into the output register and buffers it in a small FIFO. It then serialises each byte as an 8N1 UART frame on a single TX line, so OUT-instruction results can be observed off-chip. It sits beside the output register, on the same W-bus value and the same active-low LO strobe.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range is 2 and above.
FIFO_DEPTH, 4, byte entries in the buffer; must be a power of 2, 2 and above.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-low.
LO  in  1  active-low output-register load strobe from the control unit.
DATA_IN  in  8  byte being loaded into the output register; sampled on the same edge as LO.
TX  out  1  serial line; idles high.
BUSY  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
FIFO_FULL  out  1  FIFO holds FIFO_DEPTH entries.
FIFO_EMPTY  out  1  FIFO holds 0 entries.
OVF  out  1  sticky flag: a byte was dropped.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low, on port rst.
  - Reset is sampled only at posedge clk.
- Values while rst is low (effective at the next edge):
  - TX=1, BUSY=0, FIFO_FULL=0, FIFO_EMPTY=1, OVF=0.
  - Read/write pointers and count = 0; baud counter = 0; bit index = 0; state = IDLE.
  - LO_d = 1 (registered copy of LO).
- Reset mid-frame aborts the frame: TX is high after the next edge, the FIFO is flushed, and no partial frame resumes.
- Capture rule:
  - A push occurs at an edge where LO==0 and LO_d==1 (falling-edge detect).
  - LO held low for many cycles gives exactly one push.
  - The pushed byte is DATA_IN at that edge.
- Push when FIFO_FULL:
  - If a pop occurs at the same edge, the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and OVF is set to 1. OVF clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. The count is kept separately, so full and empty are unambiguous.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If FIFO_EMPTY==0 at the edge, pop the head into the shift register, clear the baud counter and go to START. There is no bypass: a byte pushed at edge N is popped at the earliest at edge N+1.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX = shift[0]. Data is sent LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles, then go to IDLE.
- TX is registered, so its value changes on the edge where the state or bit changes.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Timing:
  - Latency from the LO-falling edge N to TX low is 1 cycle (TX falls at edge N+1).
  - A frame lasts 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 1 idle cycle (TX=1 in IDLE), giving a period of 10*CLKS_PER_BIT+1.
- Output timing: BUSY, FIFO_FULL and FIFO_EMPTY are combinational from registered state. OVF is registered.
- DATA_IN is ignored except at push edges. TX never glitches, because it comes straight from a flop.

Test Plan:
1. CLKS_PER_BIT=4. Release reset, then give a one-cycle LO low with DATA_IN=0x03 at edge N -> TX=0 for cycles N+1..N+4, then data bits 1,1,0,0,0,0,0,0 for 4 cycles each, then stop bit 1 for 4 cycles. FSM returns to IDLE at edge N+41, with BUSY=0 and FIFO_EMPTY=1 after that edge; OVF=0.
2. LO held low for 5 cycles with DATA_IN=0x7E -> exactly one frame, 0x7E; no second START.
3. FIFO_DEPTH=4. Push 0x11..0x16 at edges 0,2,4,6,8,10 -> 0x11 is popped at edge 1; FIFO_FULL=1 after edge 8; 0x16 is dropped and OVF=1 after edge 10. Frames transmitted in order: 0x11,0x12,0x13,0x14,0x15.
4. Push 0xA5 then 0x5A back-to-back -> the second start bit begins exactly 1 cycle after the first stop bit ends. Bit sequence matches LSB-first; frame period is 41 cycles at CLKS_PER_BIT=4.
5. Fill the FIFO, then push on the exact edge the FSM pops -> the push is accepted, FIFO_FULL stays 1 and OVF stays 0.
6. rst low during DATA bit 3 -> after that edge TX=1, BUSY=0, FIFO_EMPTY=1 and OVF=0. After release, TX stays high with no residual frame until a new push.
